// File: rtl/box_field_ctrl.sv
// box_field_ctrl
// ----------------------------------------------------------------------------
// Manager for a field of destructible boxes on the Bomberman playfield.
// Each box is PRESENT, BURNING or GONE. An explosion rectangle that overlaps a
// PRESENT box sets it alight. A burning box counts frame ticks and then
// disappears. Every cycle the block does three things:
//   * it resolves which live box (lowest index first) covers the current VGA
//     pixel, and registers box_on/row/col/burn for the box sprite ROM;
//   * it registers four-direction movement blocking for the player sprite;
//   * it keeps a registered count of boxes that are not yet GONE.
//
// Build option (macro BOX_BURN_ANIM_EN):
//   defined   - three-state life cycle with a BURN_TICKS frame burn; burn
//               output is active.
//   undefined - an overlapping explosion removes a box at the next edge; no
//               burn counters are built, burn is tied low and frame_tick is
//               ignored.
//
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   box_x_flat/_y_flat   box i origin at bits [10i+9:10i]
//   b_x, b_y             bomberman top-left
//   v_x, v_y             current pixel
//   frame_tick           one-cycle pulse per video frame
//   exp_valid            one-cycle explosion strobe
//   exp_x0..exp_y1       inclusive explosion rectangle
//   box_on, row, col     registered sprite hit and sprite-relative address
//   burn                 selected box is burning
//   bomberman_blocked    [0] left, [1] right, [2] up, [3] down
//   boxes_left           registered count of non-GONE boxes
//   all_cleared          one-cycle pulse when boxes_left first reads 0
// ----------------------------------------------------------------------------
module box_field_ctrl #(
    parameter int NUM_BOXES  = 8,
    parameter int TILE_W     = 16,
    parameter int TILE_H     = 16,
    parameter int B_W        = 16,
    parameter int B_H        = 16,
    parameter int BURN_TICKS = 30
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [10*NUM_BOXES-1:0]        box_x_flat,
    input  logic [10*NUM_BOXES-1:0]        box_y_flat,
    input  logic [9:0]                     b_x,
    input  logic [9:0]                     b_y,
    input  logic [9:0]                     v_x,
    input  logic [9:0]                     v_y,
    input  logic                           frame_tick,
    input  logic                           exp_valid,
    input  logic [9:0]                     exp_x0,
    input  logic [9:0]                     exp_y0,
    input  logic [9:0]                     exp_x1,
    input  logic [9:0]                     exp_y1,
    output logic                           box_on,
    output logic [3:0]                     row,
    output logic [3:0]                     col,
    output logic                           burn,
    output logic [3:0]                     bomberman_blocked,
    output logic [$clog2(NUM_BOXES+1)-1:0] boxes_left,
    output logic                           all_cleared
);

    localparam int LW = $clog2(NUM_BOXES + 1);

    typedef enum logic [1:0] {
        ST_PRESENT = 2'd0,
        ST_BURNING = 2'd1,
        ST_GONE    = 2'd2
    } box_state_t;

    // ------------------------------------------------------------------------
    // Shared 11-bit geometry. The extra bit means x+W never wraps, and the
    // left/up probes are qualified by b_x/b_y being non-zero, so x-1 is never
    // evaluated below zero.
    // ------------------------------------------------------------------------
    logic [10:0] ext_bx, ext_by, ext_vx, ext_vy;
    logic [10:0] ex0, ey0, ex1, ey1;
    logic [10:0] probe_l, probe_r, probe_u, probe_d;
    logic [10:0] bx_end, by_end;
    logic        probe_l_ok, probe_u_ok;

    assign ext_bx     = {1'b0, b_x};
    assign ext_by     = {1'b0, b_y};
    assign ext_vx     = {1'b0, v_x};
    assign ext_vy     = {1'b0, v_y};
    assign ex0        = {1'b0, exp_x0};
    assign ey0        = {1'b0, exp_y0};
    assign ex1        = {1'b0, exp_x1};
    assign ey1        = {1'b0, exp_y1};
    assign probe_l    = ext_bx - 11'd1;
    assign probe_r    = ext_bx + 11'(B_W);
    assign probe_u    = ext_by - 11'd1;
    assign probe_d    = ext_by + 11'(B_H);
    assign bx_end     = ext_bx + 11'(B_W - 1);
    assign by_end     = ext_by + 11'(B_H - 1);
    assign probe_l_ok = (b_x != 10'd0);
    assign probe_u_ok = (b_y != 10'd0);

    // Per-box flags gathered into vectors for the shared reductions below.
    logic [NUM_BOXES-1:0] live;
    logic [NUM_BOXES-1:0] burning;
    logic [NUM_BOXES-1:0] pix_hit;
    logic [NUM_BOXES-1:0] blk_l, blk_r, blk_u, blk_d;
    logic [3:0]           row_off [NUM_BOXES];
    logic [3:0]           col_off [NUM_BOXES];

`ifndef BOX_BURN_ANIM_EN
    // frame_tick has no function without the burn animation.
    logic unused_frame_tick;
    assign unused_frame_tick = frame_tick;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BOXES; gi++) begin : g_box
            logic [10:0] x0, x1, y0, y1;
            logic        exp_hit;
            box_state_t  state_reg, state_next;

            assign x0 = {1'b0, box_x_flat[10*gi +: 10]};
            assign y0 = {1'b0, box_y_flat[10*gi +: 10]};
            assign x1 = x0 + 11'(TILE_W - 1);
            assign y1 = y0 + 11'(TILE_H - 1);

            // Inclusive rectangle overlap with the explosion.
            assign exp_hit = (x0 <= ex1) && (ex0 <= x1) &&
                             (y0 <= ey1) && (ey0 <= y1);

`ifdef BOX_BURN_ANIM_EN
            localparam int CW = (BURN_TICKS > 1) ? $clog2(BURN_TICKS) : 1;
            logic [CW-1:0] cnt_reg, cnt_next;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    state_reg <= ST_PRESENT;
                    cnt_reg   <= '0;
                end else begin
                    state_reg <= state_next;
                    cnt_reg   <= cnt_next;
                end
            end

            // A tick arriving together with the igniting explosion sees the
            // box still PRESENT, so it is naturally not counted.
            always_comb begin
                state_next = state_reg;
                cnt_next   = cnt_reg;
                case (state_reg)
                    ST_PRESENT: begin
                        if (exp_valid && exp_hit) begin
                            state_next = ST_BURNING;
                            cnt_next   = '0;
                        end
                    end
                    ST_BURNING: begin
                        if (frame_tick) begin
                            if (cnt_reg == CW'(BURN_TICKS - 1)) begin
                                state_next = ST_GONE;
                            end else begin
                                cnt_next = cnt_reg + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_next = state_reg;
                    end
                endcase
            end

            always_comb begin
                burning[gi] = (state_reg == ST_BURNING);
            end
`else
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    state_reg <= ST_PRESENT;
                end else begin
                    state_reg <= state_next;
                end
            end

            always_comb begin
                state_next = state_reg;
                if (state_reg == ST_PRESENT && exp_valid && exp_hit) begin
                    state_next = ST_GONE;
                end
            end

            always_comb begin
                burning[gi] = 1'b0;
            end
`endif

            always_comb begin
                live[gi] = (state_reg != ST_GONE);
            end

            assign pix_hit[gi] = live[gi] &&
                                 (ext_vx >= x0) && (ext_vx <= x1) &&
                                 (ext_vy >= y0) && (ext_vy <= y1);

            // Only the low nibble of the offset is needed, and it depends only
            // on the low nibbles of the operands.
            assign row_off[gi] = v_y[3:0] - box_y_flat[10*gi +: 4];
            assign col_off[gi] = v_x[3:0] - box_x_flat[10*gi +: 4];

            // Probe lines: a single column/row just outside the sprite, with
            // the sprite's extent on the other axis.
            assign blk_l[gi] = live[gi] && probe_l_ok &&
                               (probe_l >= x0) && (probe_l <= x1) &&
                               (y0 <= by_end) && (ext_by <= y1);
            assign blk_r[gi] = live[gi] &&
                               (probe_r >= x0) && (probe_r <= x1) &&
                               (y0 <= by_end) && (ext_by <= y1);
            assign blk_u[gi] = live[gi] && probe_u_ok &&
                               (probe_u >= y0) && (probe_u <= y1) &&
                               (x0 <= bx_end) && (ext_bx <= x1);
            assign blk_d[gi] = live[gi] &&
                               (probe_d >= y0) && (probe_d <= y1) &&
                               (x0 <= bx_end) && (ext_bx <= x1);
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Pixel priority: scan from the top so the lowest index is written last
    // and therefore wins.
    // ------------------------------------------------------------------------
    logic       hit_any;
    logic [3:0] row_sel, col_sel;
    logic       burn_sel;

    always_comb begin
        hit_any  = 1'b0;
        row_sel  = 4'd0;
        col_sel  = 4'd0;
        burn_sel = 1'b0;
        for (int i = NUM_BOXES - 1; i >= 0; i--) begin
            if (pix_hit[i]) begin
                hit_any  = 1'b1;
                row_sel  = row_off[i];
                col_sel  = col_off[i];
                burn_sel = burning[i];
            end
        end
    end

    // Population count of boxes not yet GONE.
    logic [LW-1:0] left_next;

    always_comb begin
        left_next = '0;
        for (int i = 0; i < NUM_BOXES; i++) begin
            left_next = left_next + LW'(live[i]);
        end
    end

    // ------------------------------------------------------------------------
    // Output registers.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            box_on            <= 1'b0;
            row               <= 4'd0;
            col               <= 4'd0;
            burn              <= 1'b0;
            bomberman_blocked <= 4'd0;
            boxes_left        <= LW'(NUM_BOXES);
            all_cleared       <= 1'b0;
        end else begin
            box_on            <= hit_any;
            row               <= row_sel;
            col               <= col_sel;
            burn              <= burn_sel;
            bomberman_blocked <= {|blk_d, |blk_u, |blk_r, |blk_l};
            boxes_left        <= left_next;
            // Fires only on the transition into zero, so it is one cycle wide.
            all_cleared       <= (left_next == '0) && (boxes_left != '0);
        end
    end

endmodule

// File: tb/tb_box_field_ctrl.sv
// Testbench for box_field_ctrl: two boxes at (160,50) and (177,67), 16x16
// tiles and sprite, three-tick burn. A spec-level model (per-box life state
// with a remaining-ticks countdown, integer geometry) predicts every registered
// output and is compared on every falling edge; directed checks with literal
// values pin the model to hand-worked results.
module tb_box_field_ctrl;

    localparam int NB = 2;
    localparam int TW = 16;
    localparam int TH = 16;
    localparam int BW = 16;
    localparam int BH = 16;
    localparam int BT = 3;
`ifdef BOX_BURN_ANIM_EN
    localparam bit ANIM = 1'b1;
`else
    localparam bit ANIM = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset = 1'b0;
    logic [10*NB-1:0] box_x_flat, box_y_flat;
    logic [9:0]      b_x = 10'd0, b_y = 10'd0, v_x = 10'd0, v_y = 10'd0;
    logic            frame_tick = 1'b0, exp_valid = 1'b0;
    logic [9:0]      exp_x0 = 10'd0, exp_y0 = 10'd0, exp_x1 = 10'd0, exp_y1 = 10'd0;
    logic            box_on, burn, all_cleared;
    logic [3:0]      row, col, blocked;
    logic [1:0]      boxes_left;

    int bxs[NB] = '{160, 177};
    int bys[NB] = '{50, 67};

    assign box_x_flat = {10'd177, 10'd160};
    assign box_y_flat = {10'd67, 10'd50};

    box_field_ctrl #(
        .NUM_BOXES(NB), .TILE_W(TW), .TILE_H(TH),
        .B_W(BW), .B_H(BH), .BURN_TICKS(BT)
    ) dut (
        .clk(clk), .reset(reset),
        .box_x_flat(box_x_flat), .box_y_flat(box_y_flat),
        .b_x(b_x), .b_y(b_y), .v_x(v_x), .v_y(v_y),
        .frame_tick(frame_tick), .exp_valid(exp_valid),
        .exp_x0(exp_x0), .exp_y0(exp_y0), .exp_x1(exp_x1), .exp_y1(exp_y1),
        .box_on(box_on), .row(row), .col(col), .burn(burn),
        .bomberman_blocked(blocked), .boxes_left(boxes_left),
        .all_cleared(all_cleared)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mst: 0 present, 1 burning, 2 gone; mrem: ticks still to burn.
    int mst[NB];
    int mrem[NB];
    int e_on, e_row, e_col, e_burn, e_blk, e_left, e_clr;

    function automatic bit spans(input int a0, input int a1, input int c0, input int c1);
        return (a0 <= c1) && (c0 <= a1);
    endfunction

    function automatic bit inside_range(input int p, input int lo, input int hi);
        return (p >= lo) && (p <= hi);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NB; i++) begin
            mst[i]  = 0;
            mrem[i] = 0;
        end
        e_on = 0; e_row = 0; e_col = 0; e_burn = 0; e_blk = 0;
        e_left = NB; e_clr = 0;
    endtask

    task automatic model_step();
        int bx, by, by1, bx1, n;
        bit l, r, u, d;
        bx = int'(b_x); by = int'(b_y);
        bx1 = bx + BW - 1; by1 = by + BH - 1;
        // outputs from the state as it stood before this edge
        e_on = 0; e_row = 0; e_col = 0; e_burn = 0;
        for (int i = 0; i < NB; i++) begin
            if (e_on == 0 && mst[i] != 2 &&
                inside_range(int'(v_x), bxs[i], bxs[i] + TW - 1) &&
                inside_range(int'(v_y), bys[i], bys[i] + TH - 1)) begin
                e_on   = 1;
                e_row  = int'(v_y) - bys[i];
                e_col  = int'(v_x) - bxs[i];
                e_burn = (mst[i] == 1) ? 1 : 0;
            end
        end
        l = 0; r = 0; u = 0; d = 0;
        n = 0;
        for (int i = 0; i < NB; i++) begin
            if (mst[i] != 2) begin
                n++;
                if (bx > 0 && inside_range(bx - 1, bxs[i], bxs[i] + TW - 1) &&
                    spans(by, by1, bys[i], bys[i] + TH - 1)) l = 1;
                if (inside_range(bx + BW, bxs[i], bxs[i] + TW - 1) &&
                    spans(by, by1, bys[i], bys[i] + TH - 1)) r = 1;
                if (by > 0 && inside_range(by - 1, bys[i], bys[i] + TH - 1) &&
                    spans(bx, bx1, bxs[i], bxs[i] + TW - 1)) u = 1;
                if (inside_range(by + BH, bys[i], bys[i] + TH - 1) &&
                    spans(bx, bx1, bxs[i], bxs[i] + TW - 1)) d = 1;
            end
        end
        e_blk  = {28'd0, d, u, r, l};
        e_clr  = (n == 0 && e_left != 0) ? 1 : 0;
        e_left = n;
        // life-cycle update
        for (int i = 0; i < NB; i++) begin
            if (mst[i] == 0) begin
                if (exp_valid &&
                    spans(bxs[i], bxs[i] + TW - 1, int'(exp_x0), int'(exp_x1)) &&
                    spans(bys[i], bys[i] + TH - 1, int'(exp_y0), int'(exp_y1))) begin
                    if (ANIM) begin
                        mst[i]  = 1;
                        mrem[i] = BT;
                    end else begin
                        mst[i] = 2;
                    end
                end
            end else if (mst[i] == 1 && frame_tick) begin
                mrem[i] = mrem[i] - 1;
                if (mrem[i] == 0) mst[i] = 2;
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_reset();
            else       model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            chk("box_on", int'(box_on), e_on);
            chk("row", int'(row), e_row);
            chk("col", int'(col), e_col);
            chk("burn", int'(burn), e_burn);
            chk("blocked", int'(blocked), e_blk);
            chk("boxes_left", int'(boxes_left), e_left);
            chk("all_cleared", int'(all_cleared), e_clr);
        end
    end

    // ---------------- stimulus ----------------
    task automatic adv();
        @(negedge clk);
        #1;
    endtask

    task automatic set_exp(input int x0, input int y0, input int x1, input int y1);
        exp_x0 = 10'(x0); exp_y0 = 10'(y0); exp_x1 = 10'(x1); exp_y1 = 10'(y1);
    endtask

    task automatic set_b(input int x, input int y);
        b_x = 10'(x); b_y = 10'(y);
    endtask

    task automatic set_v(input int x, input int y);
        v_x = 10'(x); v_y = 10'(y);
    endtask

    initial begin
        #2 reset = 1'b1;
        adv();
        chk("rst_box_on", int'(box_on), 0);
        chk("rst_left", int'(boxes_left), 2);
        chk("rst_blocked", int'(blocked), 0);
        chk("rst_cleared", int'(all_cleared), 0);
        reset = 1'b0;
        adv();

        // pixel resolution
        set_v(165, 55); adv();
        $display("pixel (165,55): box_on=%0d row=%0d col=%0d burn=%0d", box_on, row, col, burn);
        chk("pix0_on", int'(box_on), 1);
        chk("pix0_row", int'(row), 5);
        chk("pix0_col", int'(col), 5);
        chk("pix0_burn", int'(burn), 0);
        set_v(176, 55); adv();
        $display("pixel (176,55): box_on=%0d", box_on);
        chk("pix_gap_on", int'(box_on), 0);
        chk("pix_gap_row", int'(row), 0);
        set_v(180, 70); adv();
        $display("pixel (180,70): box_on=%0d row=%0d col=%0d", box_on, row, col);
        chk("pix1_row", int'(row), 3);
        chk("pix1_col", int'(col), 3);

        // blocking probes
        set_b(144, 50); adv();
        $display("b=(144,50) blocked=%b", blocked);
        chk("blk_right", int'(blocked), 2);
        set_b(176, 50); adv();
        $display("b=(176,50) blocked=%b", blocked);
        chk("blk_left", int'(blocked), 1);
        set_b(177, 51); adv();
        $display("b=(177,51) blocked=%b", blocked);
        chk("blk_down", int'(blocked), 8);
        set_b(177, 83); adv();
        $display("b=(177,83) blocked=%b", blocked);
        chk("blk_up", int'(blocked), 4);
        set_b(0, 0); adv();
        $display("b=(0,0) blocked=%b", blocked);
        chk("blk_origin", int'(blocked), 0);

        // explode box0
        set_b(144, 50); set_v(165, 55);
        set_exp(160, 50, 175, 65);
        exp_valid = 1'b1; adv();
        exp_valid = 1'b0; adv();
`ifdef BOX_BURN_ANIM_EN
        $display("box0 ignited: box_on=%0d burn=%0d left=%0d", box_on, burn, boxes_left);
        chk("b0_burn_on", int'(box_on), 1);
        chk("b0_burn", int'(burn), 1);
        chk("b0_burn_blk", int'(blocked), 2);
        repeat (2) begin
            frame_tick = 1'b1; adv();
            frame_tick = 1'b0; adv();
        end
        chk("b0_2ticks_burn", int'(burn), 1);
        frame_tick = 1'b1; adv();
        frame_tick = 1'b0; adv();
`endif
        $display("box0 removed: box_on=%0d burn=%0d left=%0d blocked=%b", box_on, burn, boxes_left, blocked);
        chk("b0_gone_on", int'(box_on), 0);
        chk("b0_gone_left", int'(boxes_left), 1);
        chk("b0_gone_blk", int'(blocked), 0);

        // box1: explosion and tick together, tick not counted
        set_v(180, 70);
        set_exp(180, 70, 180, 70);
        exp_valid = 1'b1; frame_tick = 1'b1; adv();
        exp_valid = 1'b0; frame_tick = 1'b0; adv();
`ifdef BOX_BURN_ANIM_EN
        chk("b1_burn", int'(burn), 1);
        frame_tick = 1'b1; adv();
        frame_tick = 1'b0; exp_valid = 1'b1; adv();   // re-explosion must not restart
        exp_valid = 1'b0; frame_tick = 1'b1; adv();
        frame_tick = 1'b0; adv();
        $display("box1 after 2 ticks: box_on=%0d burn=%0d", box_on, burn);
        chk("b1_2ticks_on", int'(box_on), 1);
        chk("b1_2ticks_burn", int'(burn), 1);
        frame_tick = 1'b1; adv();
        frame_tick = 1'b0; adv();
`endif
        $display("box1 removed: box_on=%0d left=%0d cleared=%0d", box_on, boxes_left, all_cleared);
        chk("b1_gone_on", int'(box_on), 0);
        chk("clear_left", int'(boxes_left), 0);
        chk("clear_pulse", int'(all_cleared), 1);
        adv();
        chk("clear_pulse_end", int'(all_cleared), 0);

        // explosion over both boxes, then reset mid-burn
        reset = 1'b1; adv();
        reset = 1'b0; adv();
        set_exp(0, 0, 639, 479);
        exp_valid = 1'b1; adv();
        exp_valid = 1'b0;
`ifdef BOX_BURN_ANIM_EN
        frame_tick = 1'b1; adv();
        frame_tick = 1'b0; adv();
        chk("both_burn", int'(burn), 1);
`else
        adv();
        chk("both_gone_left", int'(boxes_left), 0);
`endif
        reset = 1'b1; #1;
        $display("reset asserted: box_on=%0d left=%0d blocked=%b", box_on, boxes_left, blocked);
        chk("midrst_left", int'(boxes_left), 2);
        chk("midrst_on", int'(box_on), 0);
        chk("midrst_burn", int'(burn), 0);
        chk("midrst_blk", int'(blocked), 0);
        chk("midrst_clr", int'(all_cleared), 0);
        adv();
        reset = 1'b0; adv();
        chk("post_rst_on", int'(box_on), 1);

        // clear both together
        exp_valid = 1'b1; adv();
        exp_valid = 1'b0;
`ifdef BOX_BURN_ANIM_EN
        repeat (BT) begin
            frame_tick = 1'b1; adv();
            frame_tick = 1'b0; adv();
        end
`else
        adv();
`endif
        $display("both cleared: left=%0d cleared=%0d", boxes_left, all_cleared);
        chk("both_left", int'(boxes_left), 0);
        adv();
        adv();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion before 100000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/box_field_ctrl.md
# box_field_ctrl

Parametrised manager for a field of destructible boxes in the Bomberman playfield. It holds a per-box life state, with burn animation and removal driven by bomb explosions. Each clock it resolves which live box, if any, covers the current VGA pixel, and outputs registered ROM row/col addresses. It also produces four-direction movement blocking for the player sprite. It sits between the VGA sync/pixel counters, the bomb/explosion logic and the box sprite ROM in the top-level colour mux.

## Interface
- NUM_BOXES, 8, number of boxes (1..64)
- TILE_W, 16, box width in pixels
- TILE_H, 16, box height in pixels
- B_W, 16, bomberman sprite width
- B_H, 16, bomberman sprite height
- BURN_TICKS, 30, frame ticks a box spends burning (≥1)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- box_x_flat  in  10*NUM_BOXES  box i x origin at bits [10i+9:10i]
- box_y_flat  in  10*NUM_BOXES  box i y origin, same packing
- b_x, b_y  in  10 each  bomberman top-left
- v_x, v_y  in  10 each  current pixel
- frame_tick  in  1  one-cycle pulse per video frame
- exp_valid  in  1  one-cycle explosion strobe
- exp_x0, exp_y0, exp_x1, exp_y1  in  10 each  inclusive explosion rectangle
- box_on  out  1  live box covers pixel (registered)
- row, col  out  4 each  sprite address: row = v_y − box_y, col = v_x − box_x
- burn  out  1  selected box is burning (sprite select)
- bomberman_blocked  out  4  [0] left, [1] right, [2] up, [3] down
- boxes_left  out  $clog2(NUM_BOXES+1)  count of non-GONE boxes
- all_cleared  out  1  one-cycle pulse when boxes_left becomes 0

## Operation
- Per-box state: PRESENT, BURNING, GONE. Reset puts every box in PRESENT with burn counter 0.
- PRESENT → BURNING when exp_valid=1 and the box rectangle [x, x+TILE_W−1]×[y, y+TILE_H−1] overlaps the explosion rectangle (inclusive). The burn counter loads 0.
- exp_valid arriving while a box is BURNING or GONE is ignored for that box.
- BURNING: on each frame_tick the counter increments. On the frame_tick where counter = BURN_TICKS−1, the box goes to GONE.
- If frame_tick and the entering exp_valid arrive in the same cycle, the tick is not counted. Burn therefore lasts exactly BURN_TICKS ticks.
- GONE is terminal until reset.
- Pixel hit: a box is live if PRESENT or BURNING. Among live boxes containing (v_x, v_y), the lowest index wins and supplies row, col and burn. If no box hits, box_on=0, row=col=0, burn=0.
- Blocking counts live boxes only. Each bit is set if any live box contains the probe line:
  - left: column b_x−1, with y-overlap on [b_y, b_y+B_H−1]
  - right: column b_x+B_W, same y-span
  - up: row b_y−1, with x-overlap on [b_x, b_x+B_W−1]
  - down: row b_y+B_H, same x-span
- Arithmetic is done in 11 bits. When b_x=0 or b_y=0, the left/up probe lies off-screen and never blocks. No comparison may wrap.
- boxes_left is the registered population count of non-GONE boxes.

## Timing
- Reset values: box_on=0, row=col=0, burn=0, bomberman_blocked=0, boxes_left=NUM_BOXES, all_cleared=0.
- Pixel outputs: 1-cycle latency from v_x/v_y. The box ROM adds its own cycle downstream.
- bomberman_blocked: 1-cycle latency from b_x/b_y and from state.
- State changes take effect at the clock edge after exp_valid or frame_tick. Pixel and blocking outputs reflect a new state one further cycle later.
- boxes_left updates 1 cycle after a state change. all_cleared pulses in the same cycle boxes_left first reads 0.
- Reset asserted mid-burn immediately restores all boxes to PRESENT and clears all outputs.

## Configuration
- BOX_BURN_ANIM_EN defined: three-state behaviour as above, and burn output is active.
- BOX_BURN_ANIM_EN undefined:
  - an overlapping explosion takes PRESENT directly to GONE at the next edge
  - the burn counters are not built
  - burn is tied to 0
  - frame_tick is ignored

## Test plan
- NUM_BOXES=2, boxes (160,50),(177,67); v=(165,55) → next cycle box_on=1, row=5, col=5, burn=0. v=(176,55) → box_on=0.
- b=(144,50) → bomberman_blocked=4'b0010. b=(176,50) → 4'b0001. b=(0,0) → 4'b0000.
- BURN_TICKS=3: exp rect (160,50)-(175,65), exp_valid → box0 BURNING, burn=1 at v=(165,55). After the 3rd frame_tick, box_on=0 at (165,55), boxes_left 2→1, and b=(144,50) is no longer blocked.
- exp_valid and frame_tick in the same cycle on box1 → GONE only after 3 further ticks. A second exp_valid during the burn does not restart the counter.
- Explosion covering both boxes → boxes_left reaches 0 with a single-cycle all_cleared. Assert reset mid-burn → boxes_left=2, all outputs at reset values.
- BOX_BURN_ANIM_EN undefined: exp_valid on box0 → GONE next edge, and burn stays 0 throughout.
